arith_result_collector: RTL

//   Downstream stage of the 3-stage arithmetic pipeline: tracks issued ops, captures each 16-bit result
//   the cycle it emerges, buffers it in a DEPTH-entry FIFO with its op tag, and drains it via valid/ready.
//   The arithmetic pipe cannot stall; this block issues credits (issue_ready) so upstream never overruns it.

---
 rtl/arith_result_collector.sv | 121 ++++++++++++
 1 files changed

// File: rtl/arith_result_collector.sv
// Result collector for the 3-stage arithmetic pipe: tag pipe, credit issue, FIFO drain.
// Define COLLECTOR_BYPASS_EN to forward a result straight to the output when the FIFO is empty.
module arith_result_collector #(
   parameter int DEPTH    = 4,
   parameter int PIPE_LAT = 3,
   parameter int RES_W    = 16
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   issue_valid,
   input  logic [1:0]             issue_op,
   output logic                   issue_ready,
   input  logic [RES_W-1:0]       result,
   output logic                   out_valid,
   input  logic                   out_ready,
   output logic [RES_W-1:0]       out_data,
   output logic [1:0]             out_op,
   output logic [$clog2(DEPTH):0] count,
   output logic                   overflow
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;
   localparam int SW = $clog2(DEPTH + PIPE_LAT + 1) + 1;

   logic [PIPE_LAT-1:0]            vld_q, vld_d;
   logic [PIPE_LAT-1:0][1:0]       op_q, op_d;
   logic [DEPTH-1:0][RES_W-1:0]    data_q, data_d;
   logic [DEPTH-1:0][1:0]          tag_q, tag_d;
   logic [PW-1:0]                  rd_q, rd_d, wr_q, wr_d;
   logic [CW-1:0]                  count_q, count_d;
   logic                           ovf_q, ovf_d;

   logic                           last_vld;
   logic [1:0]                     last_op;
   logic                           push_req, push, pop, full;
   logic [SW-1:0]                  credit;

   assign last_vld = vld_q[PIPE_LAT-1];
   assign last_op  = op_q[PIPE_LAT-1];
   assign full     = (count_q == CW'(DEPTH));
   assign pop      = out_ready & (count_q != '0);

   always_comb begin
      vld_d[0] = issue_valid;
      op_d[0]  = issue_op;
      for (int i = 1; i < PIPE_LAT; i++) begin
         vld_d[i] = vld_q[i-1];
         op_d[i]  = op_q[i-1];
      end
   end

   // Credits count both stored entries and ops still inside the arithmetic pipe.
   always_comb begin
      credit = SW'(count_q);
      for (int i = 0; i < PIPE_LAT; i++)
         credit = credit + SW'(vld_q[i]);
      issue_ready = (credit < SW'(DEPTH));
   end

`ifdef COLLECTOR_BYPASS_EN
   logic byp;
   assign byp       = (count_q == '0) & last_vld;
   assign push_req  = last_vld & ~(byp & out_ready);
   assign out_valid = (count_q != '0) | byp;
   assign out_data  = byp ? result  : data_q[rd_q];
   assign out_op    = byp ? last_op : tag_q[rd_q];
`else
   assign push_req  = last_vld;
   assign out_valid = (count_q != '0);
   assign out_data  = data_q[rd_q];
   assign out_op    = tag_q[rd_q];
`endif

   // A pop in the same cycle frees the slot a full FIFO needs for the push.
   assign push = push_req & (~full | pop);

   always_comb begin
      data_d  = data_q;
      tag_d   = tag_q;
      wr_d    = wr_q;
      rd_d    = rd_q;
      ovf_d   = ovf_q;
      if (push) begin
         data_d[wr_q] = result;
         tag_d[wr_q]  = last_op;
         wr_d         = wr_q + PW'(1);
      end
      if (pop)
         rd_d = rd_q + PW'(1);
      if (push_req & ~push)
         ovf_d = 1'b1;
      count_d = count_q + CW'(push) - CW'(pop);
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         vld_q   <= '0;
         op_q    <= '0;
         data_q  <= '0;
         tag_q   <= '0;
         rd_q    <= '0;
         wr_q    <= '0;
         count_q <= '0;
         ovf_q   <= 1'b0;
      end else begin
         vld_q   <= vld_d;
         op_q    <= op_d;
         data_q  <= data_d;
         tag_q   <= tag_d;
         rd_q    <= rd_d;
         wr_q    <= wr_d;
         count_q <= count_d;
         ovf_q   <= ovf_d;
      end
   end

   assign count    = count_q;
   assign overflow = ovf_q;

endmodule
